// File: rtl/diff_pkg.sv
// rtl/diff_pkg.sv - shared default width and sign/magnitude result bundle
package diff_pkg;

   localparam int DIFF_W = 8;

   // Result bundle consumed by the downstream compare/accumulate logic.
   typedef struct packed {
      logic [DIFF_W-1:0] mag;
      logic              neg;
      logic              zero;
   } diff_res_t;

endpackage

// File: rtl/diff_mag_stage_if.sv
// rtl/diff_mag_stage_if.sv - input/output streams and counter port of diff_mag_stage
interface diff_mag_stage_if #(
   parameter int WIDTH = diff_pkg::DIFF_W,
   parameter int CNT_W = 16
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic             in_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_mag;
   logic             out_neg;
   logic             out_zero;
   logic             cnt_clr;
   logic [CNT_W-1:0] neg_count;

   modport master (
      output in_valid, in_sum, in_cout, out_ready, cnt_clr,
      input  in_ready, out_valid, out_mag, out_neg, out_zero, neg_count
   );

   modport slave (
      input  in_valid, in_sum, in_cout, out_ready, cnt_clr,
      output in_ready, out_valid, out_mag, out_neg, out_zero, neg_count
   );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell shared with the upstream subtractor
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/twos_negate.sv
// rtl/twos_negate.sv - WIDTH-bit two's complement negation (~x + 1) as a ripple of full adders
module twos_negate #(
   parameter int WIDTH = diff_pkg::DIFF_W
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             co
);

   logic [WIDTH:0] c;

   assign c[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a  (~x[i]),
         .b  (1'b0),
         .ci (c[i]),
         .s  (y[i]),
         .co (c[i+1])
      );
   end

   // Carry out of ~x + 1 is set only when x is zero.
   assign co = c[WIDTH];

endmodule

// File: rtl/diff_mag_stage.sv
// rtl/diff_mag_stage.sv - two-stage pipeline turning raw subtractor sum/cout into |a-b| with flags
module diff_mag_stage
   import diff_pkg::*;
#(
   parameter int WIDTH = DIFF_W,
   parameter int CNT_W = 16
) (
   input logic             clk,
   input logic             rst_n,
   diff_mag_stage_if.slave bus
);

   logic             s1_valid;
   logic             s2_valid;
   logic             s1_en;
   logic             s2_en;
   logic             out_fire;
   logic [WIDTH-1:0] s1_sum;
   logic             s1_cout;
   logic [WIDTH-1:0] neg_sum;
   logic             neg_co;
   logic [WIDTH-1:0] s2_mag;
   logic             s2_neg;
   logic             s2_zero;
   logic [CNT_W-1:0] cnt;

   assign s2_en    = !s2_valid || bus.out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign out_fire = s2_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_cout  <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sum  <= bus.in_sum;
            s1_cout <= bus.in_cout;
         end
      end
   end

   twos_negate #(.WIDTH(WIDTH)) u_negate (
      .x  (s1_sum),
      .y  (neg_sum),
      .co (neg_co)
   );

   // Output registers only load with a real beat, so they hold their last value while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_mag   <= '0;
         s2_neg   <= 1'b0;
         s2_zero  <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_mag  <= s1_cout ? s1_sum : neg_sum;
            s2_neg  <= !s1_cout;
            s2_zero <= s1_cout && neg_co;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (bus.cnt_clr) begin
         cnt <= '0;
      end else if (out_fire && s2_neg && !(&cnt)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.in_ready  = s1_en;
   assign bus.out_valid = s2_valid;
   assign bus.out_mag   = s2_mag;
   assign bus.out_neg   = s2_neg;
   assign bus.out_zero  = s2_zero;
   assign bus.neg_count = cnt;

endmodule

// File: tb/tb_diff_mag_stage.sv
// tb/tb_diff_mag_stage.sv - self-checking bench for diff_mag_stage
module tb_diff_mag_stage;
   import diff_pkg::*;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   int   exp_cnt16;

   diff_mag_stage_if #(.WIDTH(8), .CNT_W(16)) b16 ();
   diff_mag_stage_if #(.WIDTH(8), .CNT_W(4))  b4 ();

   diff_mag_stage #(.WIDTH(8), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   diff_mag_stage #(.WIDTH(8), .CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic diff_res_t ref_model(input logic [7:0] a, input logic [7:0] b);
      diff_res_t r;
      int ai = a;
      int bi = b;
      r.neg  = (ai < bi);
      r.zero = (ai == bi);
      r.mag  = (ai < bi) ? 8'(bi - ai) : 8'(ai - bi);
      return r;
   endfunction

   function automatic int sat_inc(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   task automatic drive16(input logic [7:0] a, input logic [7:0] b);
      b16.in_sum   = a - b;
      b16.in_cout  = (a >= b);
      b16.in_valid = 1'b1;
   endtask

   task automatic test_reset();
      n_assert++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", b16.out_valid); end
      n_assert++; if (b16.out_mag !== 8'd0) begin n_fail++; $display("FAIL reset_out_mag: got %0d expected 0", b16.out_mag); end
      n_assert++; if (b16.out_neg !== 1'b0 || b16.out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got neg=%0b zero=%0b expected 0 0", b16.out_neg, b16.out_zero); end
      n_assert++; if (b16.neg_count !== 16'd0) begin n_fail++; $display("FAIL reset_neg_count: got %0d expected 0", b16.neg_count); end
      n_assert++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", b16.in_ready); end
      n_assert++; if (b4.neg_count !== 4'd0 || b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_small: got cnt=%0d valid=%0b expected 0 0", b4.neg_count, b4.out_valid); end
   endtask

   // Raw sum/cout pairs with hand-derived results, including the unreachable cout=0,sum=0 input.
   task automatic test_vectors();
      logic [7:0] sums [5] = '{8'd145, 8'd111, 8'd0, 8'd1, 8'd0};
      logic       couts[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] mags [5] = '{8'd145, 8'd145, 8'd0, 8'd255, 8'd0};
      logic       negs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic       zeros[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         b16.out_ready = 1'b1;
         b16.in_sum    = sums[i];
         b16.in_cout   = couts[i];
         b16.in_valid  = 1'b1;
         #1;
         n_assert++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready: got %0b expected 1", i, b16.in_ready); end
         @(posedge clk); #1;
         b16.in_valid = 1'b0;
         n_assert++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_latency1: got out_valid=%0b expected 0", i, b16.out_valid); end
         @(posedge clk); #1;
         n_assert++; if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency2: got out_valid=%0b expected 1", i, b16.out_valid); end
         n_assert++; if (b16.out_mag !== mags[i] || b16.out_neg !== negs[i] || b16.out_zero !== zeros[i]) begin
            n_fail++; $display("FAIL vec%0d_result: got mag=%0d neg=%0b zero=%0b expected mag=%0d neg=%0b zero=%0b",
                               i, b16.out_mag, b16.out_neg, b16.out_zero, mags[i], negs[i], zeros[i]);
         end
         if (negs[i]) exp_cnt16 = sat_inc(exp_cnt16, 65535);
         @(posedge clk); #1;
         n_assert++; if (b16.neg_count !== 16'(exp_cnt16)) begin n_fail++; $display("FAIL vec%0d_neg_count: got %0d expected %0d", i, b16.neg_count, exp_cnt16); end
         n_assert++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_drained: got out_valid=%0b expected 0", i, b16.out_valid); end
      end
   endtask

   task automatic run_stream(input string tag, input int nbeats, input int vpct, input int rpct, output int cycles);
      diff_res_t  q[$];
      diff_res_t  r;
      logic [7:0] a, b;
      bit         offered = 0;
      int         sent = 0, got = 0, cyc = 0;
      while (got < nbeats && cyc < 5000) begin
         if (!offered && sent < nbeats && $urandom_range(99) < vpct) begin
            a = 8'($urandom); b = 8'($urandom);
            drive16(a, b);
            offered = 1;
         end else if (!offered) begin
            b16.in_valid = 1'b0;
            b16.in_sum   = 8'($urandom);
         end
         b16.out_ready = ($urandom_range(99) < rpct);
         #1;
         if (b16.out_valid && b16.out_ready) begin
            n_assert++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL %s_spurious: got unexpected beat mag=%0d expected none", tag, b16.out_mag);
            end else begin
               r = q.pop_front();
               if (b16.out_mag !== r.mag || b16.out_neg !== r.neg || b16.out_zero !== r.zero) begin
                  n_fail++; $display("FAIL %s_beat%0d: got mag=%0d neg=%0b zero=%0b expected mag=%0d neg=%0b zero=%0b",
                                     tag, got, b16.out_mag, b16.out_neg, b16.out_zero, r.mag, r.neg, r.zero);
               end
               if (r.neg) exp_cnt16 = sat_inc(exp_cnt16, 65535);
            end
            got++;
         end
         if (b16.in_valid && b16.in_ready) begin
            q.push_back(ref_model(a, b));
            sent++;
            offered = 0;
         end
         @(posedge clk); #1;
         cyc++;
         n_assert++; if (b16.neg_count !== 16'(exp_cnt16)) begin n_fail++; $display("FAIL %s_neg_count: got %0d expected %0d", tag, b16.neg_count, exp_cnt16); end
      end
      n_assert++; if (got != nbeats) begin n_fail++; $display("FAIL %s_timeout: got %0d beats expected %0d", tag, got, nbeats); end
      b16.in_valid = 1'b0;
      cycles = cyc;
   endtask

   task automatic test_back_to_back();
      int cyc;
      run_stream("b2b", 60, 100, 100, cyc);
      n_assert++; if (cyc > 62) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles expected at most 62", cyc); end
   endtask

   task automatic test_random();
      int cyc;
      run_stream("rand", 150, 70, 60, cyc);
   endtask

   task automatic test_backpressure();
      diff_res_t  q[$];
      diff_res_t  r;
      logic [7:0] a[4], b[4];
      int idx = 0, got = 0, cyc = 0;
      for (int i = 0; i < 4; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
      b16.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive16(a[idx], b[idx]);
         #1;
         if (c == 2) begin
            n_assert++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b expected 0", b16.in_ready); end
            n_assert++; if (b16.out_valid !== 1'b1 || b16.out_mag !== q[0].mag || b16.out_neg !== q[0].neg) begin
               n_fail++; $display("FAIL bp_head: got valid=%0b mag=%0d neg=%0b expected 1 %0d %0b", b16.out_valid, b16.out_mag, b16.out_neg, q[0].mag, q[0].neg);
            end
         end
         if (b16.in_valid && b16.in_ready) begin q.push_back(ref_model(a[idx], b[idx])); idx++; end
         @(posedge clk); #1;
      end
      n_assert++; if (b16.out_valid !== 1'b1 || b16.out_mag !== q[0].mag || b16.out_zero !== q[0].zero || b16.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_stable: got valid=%0b mag=%0d zero=%0b in_ready=%0b expected 1 %0d %0b 0",
                            b16.out_valid, b16.out_mag, b16.out_zero, b16.in_ready, q[0].mag, q[0].zero);
      end
      b16.out_ready = 1'b1;
      while (got < 4 && cyc < 50) begin
         if (idx < 4) drive16(a[idx], b[idx]);
         else b16.in_valid = 1'b0;
         #1;
         if (b16.out_valid && b16.out_ready) begin
            n_assert++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL bp_dup: got extra beat mag=%0d expected none", b16.out_mag);
            end else begin
               r = q.pop_front();
               if (b16.out_mag !== r.mag || b16.out_neg !== r.neg || b16.out_zero !== r.zero) begin
                  n_fail++; $display("FAIL bp_beat%0d: got mag=%0d neg=%0b zero=%0b expected mag=%0d neg=%0b zero=%0b",
                                     got, b16.out_mag, b16.out_neg, b16.out_zero, r.mag, r.neg, r.zero);
               end
               if (r.neg) exp_cnt16 = sat_inc(exp_cnt16, 65535);
            end
            got++;
         end
         if (b16.in_valid && b16.in_ready) begin q.push_back(ref_model(a[idx], b[idx])); idx++; end
         @(posedge clk); #1;
         cyc++;
      end
      b16.in_valid = 1'b0;
      n_assert++; if (got != 4 || idx != 4) begin n_fail++; $display("FAIL bp_count: got %0d out %0d in expected 4 4", got, idx); end
      n_assert++; if (b16.neg_count !== 16'(exp_cnt16)) begin n_fail++; $display("FAIL bp_neg_count: got %0d expected %0d", b16.neg_count, exp_cnt16); end
   endtask

   task automatic test_reset_midstream();
      b16.out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive16(8'($urandom_range(0, 100)), 8'($urandom_range(150, 255)));
         @(posedge clk); #1;
      end
      b16.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_cnt16 = 0;
      n_assert++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %0b expected 0", b16.out_valid); end
      n_assert++; if (b16.neg_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_neg_count: got %0d expected 0", b16.neg_count); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      b16.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         n_assert++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale%0d: got out_valid=%0b expected 0", c, b16.out_valid); end
      end
   endtask

   task automatic test_saturation();
      logic [7:0] a, b;
      int sent = 0;
      b4.out_ready = 1'b1;
      for (int c = 0; c < 19; c++) begin
         if (sent < 16) begin
            a = 8'($urandom_range(0, 254));
            b = 8'($urandom_range(255, int'(a) + 1));
            b4.in_sum   = a - b;
            b4.in_cout  = (a >= b);
            b4.in_valid = 1'b1;
         end else begin
            b4.in_valid = 1'b0;
         end
         #1;
         if (b4.in_valid && b4.in_ready) sent++;
         @(posedge clk); #1;
      end
      n_assert++; if (b4.neg_count !== 4'd15 || sent != 16) begin n_fail++; $display("FAIL sat_count: got %0d after %0d beats expected 15 after 16", b4.neg_count, sent); end
      b4.in_sum   = 8'd111;
      b4.in_cout  = 1'b0;
      b4.in_valid = 1'b1;
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      @(posedge clk); #1;
      n_assert++; if (b4.out_valid !== 1'b1 || b4.out_neg !== 1'b1) begin n_fail++; $display("FAIL clr_setup: got valid=%0b neg=%0b expected 1 1", b4.out_valid, b4.out_neg); end
      b4.cnt_clr = 1'b1;
      @(posedge clk); #1;
      b4.cnt_clr = 1'b0;
      n_assert++; if (b4.neg_count !== 4'd0) begin n_fail++; $display("FAIL clr_priority: got %0d expected 0", b4.neg_count); end
      @(posedge clk); #1;
      n_assert++; if (b4.neg_count !== 4'd0 || b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_hold: got cnt=%0d valid=%0b expected 0 0", b4.neg_count, b4.out_valid); end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      exp_cnt16 = 0;
      rst_n = 1'b0;
      b16.in_valid = 1'b0; b16.in_sum = 8'd0; b16.in_cout = 1'b0; b16.out_ready = 1'b1; b16.cnt_clr = 1'b0;
      b4.in_valid  = 1'b0; b4.in_sum  = 8'd0; b4.in_cout  = 1'b0; b4.out_ready  = 1'b1; b4.cnt_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_random();
      test_backpressure();
      test_reset_midstream();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
